gate_matvec_scheduler: RTL and testbench

Round-robin scheduler that shares one multi-pass dot-product MAC engine between NGATE matrix-vector requesters, for example the four LSTM gates. It arbitrates requests and sequences one job at a time. For each job it drives the weight-row and input-vector addresses plus the MAC clear and enable controls. It then signals completion back to the winning requester. It sits between the gate-level control logic and the dot-product datapath and its weight/input memories.

---
 rtl/gate_matvec_scheduler.sv | 149 ++++++++++++++
 tb/tb_gate_matvec_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_matvec_scheduler.sv
`default_nettype none
// gate_matvec_scheduler: round-robin arbiter plus job sequencer sharing one multi-pass MAC engine among NGATE requesters.
// Optional busyCycles/jobCount counters are built when SCHED_PERF_COUNT_EN is defined.
module gate_matvec_scheduler #(
  parameter int NGATE          = 4,
  parameter int GATE_BITWIDTH  = 2,
  parameter int NCOL           = 16,
  parameter int ADDR_BITWIDTH  = 4,
  parameter int DSP48_PER_ROW  = 2,
  parameter int MUX_BITWIDTH   = 1,
  parameter int ENGINE_LATENCY = 1
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [NGATE-1:0]                                     req,
  output logic [NGATE-1:0]                                     grant,
  output logic [NGATE-1:0]                                     done,
  output logic                                                 busy,
  output logic [GATE_BITWIDTH+MUX_BITWIDTH+ADDR_BITWIDTH-1:0]  weightAddr,
  output logic [ADDR_BITWIDTH-1:0]                             inputAddr,
  output logic                                                 macClear,
  output logic                                                 macEn,
  output logic                                                 resultCapture
`ifdef SCHED_PERF_COUNT_EN
  ,
  output logic [31:0]                                          busyCycles,
  output logic [15:0]                                          jobCount
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST   = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic [MUX_BITWIDTH-1:0]  PASS_LAST  = MUX_BITWIDTH'(DSP48_PER_ROW - 1);
  localparam int                       DRAIN_LAST = (ENGINE_LATENCY > 0) ? ENGINE_LATENCY - 1 : 0;

  logic [1:0]               state;
  logic [GATE_BITWIDTH-1:0] gate_q;
  logic [MUX_BITWIDTH-1:0]  pass_q;
  logic [ADDR_BITWIDTH-1:0] col_q;
  logic [NGATE-1:0]         grant_q;
  logic [GATE_BITWIDTH-1:0] ptr;
  logic [15:0]              drain_cnt;

  logic [2*NGATE-1:0]       req_dbl;
  logic [NGATE-1:0]         req_rot;
  int                       offset;
  logic [GATE_BITWIDTH-1:0] winner;
  logic [GATE_BITWIDTH-1:0] ptr_next;
  logic                     last_beat;

  // Rotating the request vector by the pointer turns round-robin into a lowest-set-bit search.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NGATE-1:0];

  always_comb begin
    offset = 0;
    for (int j = NGATE - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        offset = j;
      end
    end
  end

  assign winner    = GATE_BITWIDTH'((int'(ptr) + offset) % NGATE);
  assign ptr_next  = GATE_BITWIDTH'((int'(winner) + 1) % NGATE);
  assign last_beat = (col_q == COL_LAST) && (pass_q == PASS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      gate_q    <= '0;
      pass_q    <= '0;
      col_q     <= '0;
      grant_q   <= '0;
      ptr       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state   <= S_RUN;
            gate_q  <= winner;
            grant_q <= {{(NGATE-1){1'b0}}, 1'b1} << winner;
            ptr     <= ptr_next;
            pass_q  <= '0;
            col_q   <= '0;
          end
        end
        S_RUN: begin
          // Counters stop on the last beat so the addresses hold their final value afterwards.
          if (last_beat) begin
            drain_cnt <= '0;
            state     <= (ENGINE_LATENCY == 0) ? S_DONE : S_DRAIN;
          end else if (col_q == COL_LAST) begin
            col_q  <= '0;
            pass_q <= pass_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 16'(DRAIN_LAST)) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          grant_q <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign busy          = (state != S_IDLE);
  assign macEn         = (state == S_RUN);
  assign macClear      = (state == S_RUN) && (pass_q == '0) && (col_q == '0);
  assign resultCapture = (state == S_DONE);
  assign done          = (state == S_DONE) ? grant_q : '0;
  assign weightAddr    = {gate_q, pass_q, col_q};
  assign inputAddr     = col_q;

`ifdef SCHED_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      busyCycles <= '0;
      jobCount   <= '0;
    end else begin
      if (busy && (busyCycles != '1)) begin
        busyCycles <= busyCycles + 32'd1;
      end
      if (resultCapture && (jobCount != '1)) begin
        jobCount <= jobCount + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_matvec_scheduler.sv
`default_nettype none
// Bench for gate_matvec_scheduler: table-driven single-job probes, corner sequences,
// and randomized traffic against a job-level reference model.
module tb_gate_matvec_scheduler;
  localparam int NGATE  = 4;
  localparam int GW     = 2;
  localparam int NCOL   = 16;
  localparam int AW     = 4;
  localparam int PASSES = 2;
  localparam int MW     = 1;
  localparam int LAT    = 1;
  localparam int WAW    = GW + MW + AW;
  localparam int BEATS  = NCOL * PASSES;
  localparam int TOTAL  = BEATS + LAT + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NGATE-1:0] req = '0;
  logic [NGATE-1:0] grant, done;
  logic             busy, macClear, macEn, resultCapture;
  logic [WAW-1:0]   weightAddr;
  logic [AW-1:0]    inputAddr;
`ifdef SCHED_PERF_COUNT_EN
  logic [31:0]      busyCycles;
  logic [15:0]      jobCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_matvec_scheduler #(
    .NGATE(NGATE), .GATE_BITWIDTH(GW), .NCOL(NCOL), .ADDR_BITWIDTH(AW),
    .DSP48_PER_ROW(PASSES), .MUX_BITWIDTH(MW), .ENGINE_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant), .done(done), .busy(busy),
    .weightAddr(weightAddr), .inputAddr(inputAddr), .macClear(macClear),
    .macEn(macEn), .resultCapture(resultCapture)
`ifdef SCHED_PERF_COUNT_EN
    , .busyCycles(busyCycles), .jobCount(jobCount)
`endif
  );

  // Job-level model: t = 0 idle, 1..BEATS MAC beats, then drain, TOTAL = done cycle.
  typedef struct {
    int             t;
    int             owner;
    int             ptr;
    logic [WAW-1:0] addr;
    longint         busy_cnt;
    longint         jobs;
  } mstate_t;

  mstate_t m = '{0, 0, 0, '0, 0, 0};

  function automatic mstate_t model_step(input mstate_t s, input logic rst, input logic [NGATE-1:0] r);
    mstate_t n;
    bit      found;
    int      k;
    n = s;
    found = 1'b0;
    if (rst) begin
      n = '{0, 0, 0, '0, 0, 0};
    end else begin
      if (s.t != 0 && s.busy_cnt < 64'hFFFF_FFFF) n.busy_cnt = s.busy_cnt + 1;
      if (s.t == TOTAL && s.jobs < 64'hFFFF) n.jobs = s.jobs + 1;
      if (s.t == 0) begin
        if (r != '0) begin
          for (int i = 0; i < NGATE; i++) begin
            k = (s.ptr + i) % NGATE;
            if (!found && r[k]) begin
              found = 1'b1;
              n.owner = k;
            end
          end
          n.ptr = (n.owner + 1) % NGATE;
          n.t = 1;
        end
      end else if (s.t == TOTAL) begin
        n.t = 0;
      end else begin
        n.t = s.t + 1;
      end
      if (n.t >= 1 && n.t <= BEATS)
        n.addr = WAW'((n.owner << (MW + AW)) | (((n.t - 1) / NCOL) << AW) | ((n.t - 1) % NCOL));
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, reset, req);

  function automatic logic [NGATE-1:0] onehot(input int g);
    onehot = '0;
    onehot[g] = 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_grant", grant, (m.t != 0) ? onehot(m.owner) : '0);
    check("m_busy", busy, m.t != 0);
    check("m_macEn", macEn, (m.t >= 1) && (m.t <= BEATS));
    check("m_macClear", macClear, m.t == 1);
    check("m_resultCapture", resultCapture, m.t == TOTAL);
    check("m_done", done, (m.t == TOTAL) ? onehot(m.owner) : '0);
    check("m_weightAddr", weightAddr, m.addr);
    check("m_inputAddr", inputAddr, m.addr[AW-1:0]);
`ifdef SCHED_PERF_COUNT_EN
    check("m_busyCycles", busyCycles, m.busy_cnt);
    check("m_jobCount", jobCount, m.jobs);
`endif
  end

  typedef struct {
    int             cyc;
    logic [3:0]     grant;
    logic [3:0]     done;
    logic           busy, clr, en, cap;
    logic [WAW-1:0] waddr;
    logic [AW-1:0]  iaddr;
  } probe_t;

  probe_t probes[9];

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_start(input string name, output logic [NGATE-1:0] g, output int n);
    n = 0;
    g = '0;
    while (!macClear && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!macClear) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for job start", name);
    end else begin
      g = grant;
    end
  endtask

  task automatic wait_done(input string name, output logic [NGATE-1:0] d);
    int n = 0;
    d = '0;
    while (done == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done == '0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for done", name);
    end else begin
      d = done;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NGATE-1:0] g, d;
    int               n;
    logic [3:0]       gseq[8];
    int               dt[8];
    int               ng, nd;
    bit               seen;
    logic [3:0]       exp_rr[5];

    probes[0] = '{0,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 4'h0};
    probes[1] = '{1,  4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 7'h20, 4'h0};
    probes[2] = '{2,  4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 7'h21, 4'h1};
    probes[3] = '{16, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 7'h2F, 4'hF};
    probes[4] = '{17, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 7'h30, 4'h0};
    probes[5] = '{32, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 7'h3F, 4'hF};
    probes[6] = '{33, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 7'h3F, 4'hF};
    probes[7] = '{34, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 7'h3F, 4'hF};
    probes[8] = '{35, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 7'h3F, 4'hF};
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Single job for gate 1, probed at fixed cycles.
    do_reset();
    for (int c = 0; c <= 35; c++) begin
      if (c > 0) @(negedge clk);
      for (int p = 0; p < 9; p++) begin
        if (probes[p].cyc == c) begin
          check($sformatf("single_grant_c%0d", c), grant, probes[p].grant);
          check($sformatf("single_done_c%0d", c), done, probes[p].done);
          check($sformatf("single_busy_c%0d", c), busy, probes[p].busy);
          check($sformatf("single_clr_c%0d", c), macClear, probes[p].clr);
          check($sformatf("single_en_c%0d", c), macEn, probes[p].en);
          check($sformatf("single_cap_c%0d", c), resultCapture, probes[p].cap);
          check($sformatf("single_waddr_c%0d", c), weightAddr, probes[p].waddr);
          check($sformatf("single_iaddr_c%0d", c), inputAddr, probes[p].iaddr);
        end
      end
      req = (c <= 34) ? 4'b0010 : 4'b0000;
    end

    // Contention rotation: gate 2 wins, then pending 0101 must go to gate 0.
    req = 4'b0100;
    wait_start("rot_start1", g, n);
    check("rot_first", g, 4'b0100);
    req = 4'b0101;
    wait_done("rot_done1", d);
    check("rot_done1", d, 4'b0100);
    wait_start("rot_start2", g, n);
    check("rot_second", g, 4'b0001);
    check("rot_b2b_gap", n, 2);
    wait_done("rot_done2", d);
    check("rot_done2", d, 4'b0001);
    req = 4'b0100;
    wait_start("rot_start3", g, n);
    check("rot_third", g, 4'b0100);
    wait_done("rot_done3", d);
    req = '0;

    // All requests high: strict rotation and 35-cycle job period.
    do_reset();
    req = '1;
    ng = 0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      gseq[i] = '0;
      dt[i] = 0;
    end
    for (int c = 0; c < 180; c++) begin
      if (c > 0) @(negedge clk);
      if (macClear && ng < 8) begin
        gseq[ng] = grant;
        ng++;
      end
      if (done != '0 && nd < 8) begin
        dt[nd] = c;
        nd++;
      end
    end
    for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), gseq[i], exp_rr[i]);
    check("rr_first_done_cycle", dt[0], 34);
    for (int i = 1; i < 5; i++) check($sformatf("rr_done_spacing%0d", i), dt[i] - dt[i-1], 35);

    // Reset in the middle of a job.
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_en", macEn, 0);
    check("rst_done", done, 0);
    check("rst_waddr", weightAddr, 0);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done != '0 || resultCapture) seen = 1'b1;
    end
    check("rst_no_done", seen, 0);
    req = 4'b0101;
    wait_start("rst_restart", g, n);
    check("rst_ptr_restart", g, 4'b0001);
    wait_done("rst_restart_done", d);
    req = '0;

    // Request withdrawn mid-job: job still completes, nothing follows.
    do_reset();
    req = 4'b1000;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 5) req = '0;
    end
    check("drop_done", done, 4'b1000);
    check("drop_cap", resultCapture, 1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grant != '0 || macEn) seen = 1'b1;
    end
    check("drop_no_regrant", seen, 0);

`ifdef SCHED_PERF_COUNT_EN
    do_reset();
    check("perf_reset_busy", busyCycles, 0);
    check("perf_reset_jobs", jobCount, 0);
    req = 4'b0011;
    wait_done("perf_done1", d);
    req = 4'b0010;
    @(negedge clk);
    wait_done("perf_done2", d);
    req = '0;
    @(negedge clk);
    check("perf_jobs", jobCount, 2);
    check("perf_busy", busyCycles, 68);
`endif

    // Randomized traffic checked every cycle against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      for (int gi = 0; gi < NGATE; gi++) begin
        if (req[gi]) begin
          if (m.t == TOTAL && m.owner == gi) req[gi] = 1'($urandom_range(0, 1));
          else if ($urandom_range(0, 199) == 0) req[gi] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req[gi] = 1'b1;
        end
      end
    end
    reset = 1'b0;
    req = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
